dec_stage: RTL and testbench
============================

// Module: dec_stage
// PURPOSE
//  Registered, parametrised instruction-decode stage; successor to the combinational decoder.
//  Splits the fetched word into op, register fields, const flag, branch amount and write enables,
//  using the same R/load/store/J classes. Sits between fetch and execute.
//  Uses valid/ready handshakes on both sides and a load-use scoreboard that stalls fetch on RAW/WAW.
// PARAMETERS
//  INST_W   20  instruction width; op = inst[INST_W-1 -: OP_W]
//  OP_W     5   opcode width
//  REG_W    5   register-field width; register count = 2**REG_W
//  BAMT_W   15  branch-amount width; bamt = inst[BAMT_W-1:0]
//  LD_LAT   2   cycles (>=1) from load issue until its destination is readable
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  flush      in   1       sync; kill held instruction
//  in_valid   in   1       fetch word valid
//  in_ready   out  1       stage accepts word this cycle
//  inst       in   INST_W  instruction word
//  out_valid  out  1       decoded instruction valid
//  out_ready  in   1       execute accepts decoded instruction
//  op         out  OP_W    registered opcode
//  rs,rt,rd   out  REG_W   registered register fields
//  const_flag out  1       rt field is a constant
//  bamt       out  BAMT_W  branch amount (J-type only, else 0)
//  we_rf      out  1       writes register file
//  we_dmem    out  1       writes data memory
//  is_load    out  1       load instruction
//  stall_cnt  out  16      saturating count of hazard-stall cycles
// BEHAVIOUR
//  Fields (f2 = inst[3*REG_W-1 -: REG_W], f1 = inst[2*REG_W-1 -: REG_W], f0 = inst[REG_W-1:0]):
//   R  (op<7 | op==11): rd=f2 rs=f1 rt=f0 const_flag=f0[REG_W-1] we_rf=1
//   LD (op==12): rd=f2 rt=f1 rs=f0 const_flag=1 we_rf=1 is_load=1
//   ST (op==13): rs=f2 rd=f1 const_flag=1 we_dmem=1
//   J  (other): bamt=inst[BAMT_W-1:0]
//   Unused fields and flags are 0.
//  Sources checked for hazards:
//   R: rs, plus rt if !const_flag
//   LD: rs
//   ST: rs and rd (store data)
//   J: none
//   Also checked: the destination rd of any instruction with we_rf=1.
//   Register 0 never hazards.
//  Scoreboard: per-register down-counter, width $clog2(LD_LAT+1), reset 0.
//   busy(r) = cnt[r]!=0.
//   On issue (out_valid & out_ready & is_load, rd!=0): cnt[rd] <= LD_LAT.
//   Otherwise each nonzero cnt decrements by 1 every cycle.
//   Set beats decrement on the same register in the same cycle.
//  hazard (comb) = in_valid & (any checked reg is busy, or matches rd of a held, not-yet-issued load).
//  in_ready = (!out_valid | out_ready) & !hazard & !flush.
//  Accept (in_valid & in_ready): output registers load the decode of inst; out_valid <= 1.
//   Latency is 1 cycle.
//  Held (out_valid & !out_ready): all outputs stable; no new accept.
//  Issue without accept: out_valid <= 0; fields keep their values.
//  flush: out_valid <= 0 next cycle. The held instruction is not issued, so no scoreboard set.
//   Scoreboard counters keep running.
//  stall_cnt increments on every cycle with hazard=1; saturates at 16'hFFFF.
//  Reset (async, rst_n=0): out_valid=0, all fields/flags=0, scoreboard=0, stall_cnt=0.
//   Reset mid-stall drops the instruction; release is synchronous to clk.
// TESTING
//  1. R-type 0x0_1483 (op=0, f2=5, f1=4, f0=3), out_ready=1
//     -> next cycle out_valid=1, rd=5 rs=4 rt=3, const_flag=0, we_rf=1.
//  2. LD rd=7 issued, then R-type with rs=7
//     -> in_ready=0 for LD_LAT cycles (2); accepted on cycle 3; stall_cnt=2.
//  3. Held LD rd=9 (out_ready=0), then ST with rd=9 offered
//     -> in_ready=0 until LD issues and the counter expires; ST fields rs=f2, rd=f1, we_dmem=1.
//  4. J op=20, inst[14:0]=0x1234 -> bamt=0x1234; rs=rt=rd=0; we_rf=we_dmem=0; never stalls.
//  5. out_ready=0 for 5 cycles with in_valid=1 -> outputs stable; in_ready=0; no second accept.
//  6. flush with a held LD rd=3 -> out_valid=0 next cycle; a later read of r3 does not stall.
//     rst_n pulse mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/dec_stage.sv
// Registered instruction-decode stage between fetch and execute.
// Valid/ready on both sides, plus a per-register load-use scoreboard that stalls fetch on RAW/WAW.
module dec_stage #(
  parameter int INST_W = 20,
  parameter int OP_W   = 5,
  parameter int REG_W  = 5,
  parameter int BAMT_W = 15,
  parameter int LD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   op,
  output logic [REG_W-1:0]  rs,
  output logic [REG_W-1:0]  rt,
  output logic [REG_W-1:0]  rd,
  output logic              const_flag,
  output logic [BAMT_W-1:0] bamt,
  output logic              we_rf,
  output logic              we_dmem,
  output logic              is_load,
  output logic [15:0]       stall_cnt
);

  localparam int NREG  = 2 ** REG_W;
  localparam int CNT_W = $clog2(LD_LAT + 1);
  localparam logic [OP_W-1:0] OP_RLIM = OP_W'(7);
  localparam logic [OP_W-1:0] OP_R11  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_LD   = OP_W'(12);
  localparam logic [OP_W-1:0] OP_ST   = OP_W'(13);

  logic [REG_W-1:0]  f2, f1, f0;
  logic [OP_W-1:0]   op_d, op_q;
  logic [REG_W-1:0]  rs_d, rt_d, rd_d, rs_q, rt_q, rd_q;
  logic              cf_d, cf_q, we_rf_d, we_rf_q, we_dmem_d, we_dmem_q, ld_d, ld_q;
  logic [BAMT_W-1:0] bamt_d, bamt_q;
  logic              chk_rs, chk_rt, chk_rd;
  logic              out_valid_d, out_valid_q;
  logic [15:0]       stall_d, stall_q;
  logic [NREG-1:0][CNT_W-1:0] cnt_d, cnt_q;
  logic [NREG-1:0]   busy;
  logic              hazard, accept, issue, issue_ld;

  assign f2 = inst[3*REG_W-1 -: REG_W];
  assign f1 = inst[2*REG_W-1 -: REG_W];
  assign f0 = inst[REG_W-1:0];

  always_comb begin
    op_d      = inst[INST_W-1 -: OP_W];
    rs_d      = '0;
    rt_d      = '0;
    rd_d      = '0;
    cf_d      = 1'b0;
    bamt_d    = '0;
    we_rf_d   = 1'b0;
    we_dmem_d = 1'b0;
    ld_d      = 1'b0;
    chk_rs    = 1'b0;
    chk_rt    = 1'b0;
    chk_rd    = 1'b0;
    if (op_d < OP_RLIM || op_d == OP_R11) begin
      rd_d    = f2;
      rs_d    = f1;
      rt_d    = f0;
      cf_d    = f0[REG_W-1];
      we_rf_d = 1'b1;
      chk_rs  = 1'b1;
      chk_rt  = !f0[REG_W-1];
      chk_rd  = 1'b1;
    end else if (op_d == OP_LD) begin
      rd_d    = f2;
      rt_d    = f1;
      rs_d    = f0;
      cf_d    = 1'b1;
      we_rf_d = 1'b1;
      ld_d    = 1'b1;
      chk_rs  = 1'b1;
      chk_rd  = 1'b1;
    end else if (op_d == OP_ST) begin
      rs_d      = f2;
      rd_d      = f1;
      cf_d      = 1'b1;
      we_dmem_d = 1'b1;
      chk_rs    = 1'b1;
      chk_rd    = 1'b1;
    end else begin
      bamt_d = inst[BAMT_W-1:0];
    end
  end

  // A load still sitting in the output register blocks its rd before the counter starts.
  always_comb begin
    busy = '0;
    for (int i = 1; i < NREG; i++) begin
      busy[i] = (cnt_q[i] != '0) || (out_valid_q && ld_q && rd_q == REG_W'(i));
    end
  end

  assign hazard   = in_valid & ((chk_rs & busy[rs_d]) | (chk_rt & busy[rt_d]) | (chk_rd & busy[rd_d]));
  assign in_ready = (!out_valid_q | out_ready) & !hazard & !flush;
  assign accept   = in_valid & in_ready;
  assign issue    = out_valid_q & out_ready & !flush;
  assign issue_ld = issue & ld_q & (rd_q != '0);

  always_comb begin
    out_valid_d = out_valid_q;
    if (accept) begin
      out_valid_d = 1'b1;
    end else if (issue || flush) begin
      out_valid_d = 1'b0;
    end
    stall_d = (hazard && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    for (int i = 0; i < NREG; i++) begin
      if (issue_ld && rd_q == REG_W'(i)) begin
        cnt_d[i] = CNT_W'(LD_LAT);
      end else if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      stall_q     <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      cf_q        <= 1'b0;
      bamt_q      <= '0;
      we_rf_q     <= 1'b0;
      we_dmem_q   <= 1'b0;
      ld_q        <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      stall_q     <= stall_d;
      cnt_q       <= cnt_d;
      if (accept) begin
        op_q      <= op_d;
        rs_q      <= rs_d;
        rt_q      <= rt_d;
        rd_q      <= rd_d;
        cf_q      <= cf_d;
        bamt_q    <= bamt_d;
        we_rf_q   <= we_rf_d;
        we_dmem_q <= we_dmem_d;
        ld_q      <= ld_d;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign op         = op_q;
  assign rs         = rs_q;
  assign rt         = rt_q;
  assign rd         = rd_q;
  assign const_flag = cf_q;
  assign bamt       = bamt_q;
  assign we_rf      = we_rf_q;
  assign we_dmem    = we_dmem_q;
  assign is_load    = ld_q;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_dec_stage.sv
// Bench for dec_stage: directed scenarios plus randomized traffic against a cycle-level reference model
// that tracks register ready times as absolute cycle numbers.
module tb_dec_stage;
  localparam int INST_W = 20, OP_W = 5, REG_W = 5, BAMT_W = 15, LD_LAT = 2;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [INST_W-1:0] inst;
  logic [OP_W-1:0]   op;
  logic [REG_W-1:0]  rs, rt, rd;
  logic              const_flag, we_rf, we_dmem, is_load;
  logic [BAMT_W-1:0] bamt;
  logic [15:0]       stall_cnt;

  dec_stage #(.INST_W(INST_W), .OP_W(OP_W), .REG_W(REG_W), .BAMT_W(BAMT_W), .LD_LAT(LD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .out_valid(out_valid), .out_ready(out_ready), .op(op), .rs(rs), .rt(rt),
    .rd(rd), .const_flag(const_flag), .bamt(bamt), .we_rf(we_rf), .we_dmem(we_dmem),
    .is_load(is_load), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        cf;
    logic [14:0] bamt;
    logic        we_rf;
    logic        we_dmem;
    logic        ld;
  } dec_t;

  dec_t dut_f;
  assign dut_f = {op, rs, rt, rd, const_flag, bamt, we_rf, we_dmem, is_load};

  int   n_cmp = 0, n_bad = 0;
  dec_t m;
  bit   m_valid;
  int   ready_at[32];
  int   cyc = 0;
  int   m_stall;
  bit   m_haz, m_rdy;

  function automatic dec_t ref_decode(input logic [19:0] w);
    dec_t d;
    int v, opc, a, b, c;
    v = int'(w);
    opc = v / 32768;
    a = (v / 1024) % 32;
    b = (v / 32) % 32;
    c = v % 32;
    d = '0;
    d.op = 5'(opc);
    if (opc < 7 || opc == 11) begin
      d.rd = 5'(a); d.rs = 5'(b); d.rt = 5'(c); d.cf = (c >= 16); d.we_rf = 1'b1;
    end else if (opc == 12) begin
      d.rd = 5'(a); d.rt = 5'(b); d.rs = 5'(c); d.cf = 1'b1; d.we_rf = 1'b1; d.ld = 1'b1;
    end else if (opc == 13) begin
      d.rs = 5'(a); d.rd = 5'(b); d.cf = 1'b1; d.we_dmem = 1'b1;
    end else begin
      d.bamt = 15'(v % 32768);
    end
    return d;
  endfunction

  function automatic bit reg_busy(input int r);
    return (r != 0) && ((cyc < ready_at[r]) || (m_valid && m.ld && int'(m.rd) == r));
  endfunction

  function automatic bit ref_hazard(input logic [19:0] w);
    dec_t d;
    int opc;
    d = ref_decode(w);
    opc = int'(d.op);
    if (opc < 7 || opc == 11)
      return reg_busy(int'(d.rs)) || (!d.cf && reg_busy(int'(d.rt))) || reg_busy(int'(d.rd));
    if (opc == 12 || opc == 13)
      return reg_busy(int'(d.rs)) || reg_busy(int'(d.rd));
    return 1'b0;
  endfunction

  task automatic model_reset();
    m = '0;
    m_valid = 1'b0;
    m_stall = 0;
    for (int i = 0; i < 32; i++) ready_at[i] = 0;
  endtask

  // Drive inputs right after an edge, then settle to the falling edge and predict the combinational outputs.
  task automatic set_in(input bit iv, input logic [19:0] w, input bit ordy, input bit fl);
    in_valid = iv; inst = w; out_ready = ordy; flush = fl;
    @(negedge clk);
    m_haz = iv && ref_hazard(w);
    m_rdy = (!m_valid || ordy) && !m_haz && !fl;
  endtask

  task automatic tick();
    bit issue;
    @(posedge clk);
    issue = m_valid && out_ready && !flush;
    if (issue && m.ld && m.rd != 5'd0) ready_at[m.rd] = cyc + LD_LAT + 1;
    if (in_valid && m_rdy) begin
      m = ref_decode(inst);
      m_valid = 1'b1;
    end else if (issue || flush) begin
      m_valid = 1'b0;
    end
    if (m_haz && m_stall < 65535) m_stall++;
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; inst = '0; out_ready = 1'b0; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (dut_f !== '0) begin n_bad++; $display("FAIL reset_fields: got %h want 0", dut_f); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    set_in(1'b1, 20'h01483, 1'b1, 1'b0);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rtype_in_ready: got %b want 1", in_ready); end
    tick();
    set_in(1'b0, 20'h0, 1'b1, 1'b0);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rtype_out_valid: got %b want 1", out_valid); end
    n_cmp++; if ({rd, rs, rt} !== {5'd5, 5'd4, 5'd3}) begin n_bad++; $display("FAIL rtype_regs: got rd=%0d rs=%0d rt=%0d want 5 4 3", rd, rs, rt); end
    n_cmp++; if ({const_flag, we_rf, we_dmem, is_load} !== 4'b0100) begin n_bad++; $display("FAIL rtype_flags: got %b want 0100", {const_flag, we_rf, we_dmem, is_load}); end
    tick();
  endtask

  task automatic test_load_use();
    int base;
    set_in(1'b1, (20'd12 << 15) | (20'd7 << 10) | 20'd1, 1'b1, 1'b0);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL lduse_ld_accept: got %b want 1", in_ready); end
    tick();
    set_in(1'b0, 20'h0, 1'b1, 1'b0);
    tick();
    base = m_stall;
    for (int k = 1; k <= 3; k++) begin
      set_in(1'b1, (20'd2 << 10) | (20'd7 << 5) | 20'd3, 1'b1, 1'b0);
      n_cmp++; if (in_ready !== (k == 3)) begin n_bad++; $display("FAIL lduse_in_ready_c%0d: got %b want %b", k, in_ready, (k == 3)); end
      tick();
    end
    set_in(1'b0, 20'h0, 1'b1, 1'b0);
    n_cmp++; if (stall_cnt !== 16'(base + 2)) begin n_bad++; $display("FAIL lduse_stall_cnt: got %0d want %0d", stall_cnt, base + 2); end
    n_cmp++; if ({out_valid, rs} !== {1'b1, 5'd7}) begin n_bad++; $display("FAIL lduse_out: got v=%b rs=%0d want v=1 rs=7", out_valid, rs); end
    tick();
  endtask

  task automatic test_held_ld_store();
    logic [19:0] st;
    st = (20'd13 << 15) | (20'd4 << 10) | (20'd9 << 5);
    set_in(1'b1, (20'd12 << 15) | (20'd9 << 10) | 20'd2, 1'b1, 1'b0);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL heldst_ld_accept: got %b want 1", in_ready); end
    tick();
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, st, 1'b0, 1'b0);
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL heldst_held_in_ready: got %b want 0", in_ready); end
      n_cmp++; if ({out_valid, is_load, rd} !== {1'b1, 1'b1, 5'd9}) begin n_bad++; $display("FAIL heldst_held_out: got v=%b ld=%b rd=%0d want 1 1 9", out_valid, is_load, rd); end
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, st, 1'b1, 1'b0);
      n_cmp++; if (in_ready !== (k == 3)) begin n_bad++; $display("FAIL heldst_in_ready_c%0d: got %b want %b", k, in_ready, (k == 3)); end
      tick();
    end
    set_in(1'b0, 20'h0, 1'b1, 1'b0);
    n_cmp++; if ({op, rs, rt, rd} !== {5'd13, 5'd4, 5'd0, 5'd9}) begin n_bad++; $display("FAIL heldst_regs: got op=%0d rs=%0d rt=%0d rd=%0d want 13 4 0 9", op, rs, rt, rd); end
    n_cmp++; if ({const_flag, we_rf, we_dmem, is_load} !== 4'b1010) begin n_bad++; $display("FAIL heldst_flags: got %b want 1010", {const_flag, we_rf, we_dmem, is_load}); end
    tick();
  endtask

  task automatic test_jtype();
    set_in(1'b1, (20'd12 << 15) | (20'd4 << 10), 1'b1, 1'b0);
    tick();
    set_in(1'b1, (20'd20 << 15) | 20'h1234, 1'b1, 1'b0);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL jtype_in_ready: got %b want 1", in_ready); end
    tick();
    set_in(1'b0, 20'h0, 1'b1, 1'b0);
    n_cmp++; if ({op, bamt} !== {5'd20, 15'h1234}) begin n_bad++; $display("FAIL jtype_bamt: got op=%0d bamt=%h want 20 1234", op, bamt); end
    n_cmp++; if ({rs, rt, rd, const_flag, we_rf, we_dmem, is_load} !== 19'd0) begin n_bad++; $display("FAIL jtype_zero: got rs=%0d rt=%0d rd=%0d flags=%b want zeros", rs, rt, rd, {const_flag, we_rf, we_dmem, is_load}); end
    tick();
  endtask

  task automatic test_hold();
    logic [19:0] a, b;
    a = (20'd3 << 15) | (20'd10 << 10) | (20'd11 << 5) | 20'd12;
    b = (20'd5 << 15) | (20'd13 << 10) | (20'd14 << 5) | 20'd15;
    set_in(1'b1, a, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      set_in(1'b1, b, 1'b0, 1'b0);
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL hold_in_ready_c%0d: got %b want 0", k, in_ready); end
      n_cmp++; if ({out_valid, op, rd, rs, rt} !== {1'b1, 5'd3, 5'd10, 5'd11, 5'd12}) begin n_bad++; $display("FAIL hold_stable_c%0d: got v=%b op=%0d rd=%0d rs=%0d rt=%0d", k, out_valid, op, rd, rs, rt); end
      tick();
    end
    set_in(1'b1, b, 1'b1, 1'b0);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL hold_release: got %b want 1", in_ready); end
    tick();
    set_in(1'b0, 20'h0, 1'b1, 1'b0);
    n_cmp++; if ({out_valid, op, rd} !== {1'b1, 5'd5, 5'd13}) begin n_bad++; $display("FAIL hold_second: got v=%b op=%0d rd=%0d want 1 5 13", out_valid, op, rd); end
    tick();
  endtask

  task automatic test_flush_and_reset();
    set_in(1'b1, (20'd12 << 15) | (20'd3 << 10), 1'b0, 1'b0);
    tick();
    set_in(1'b0, 20'h0, 1'b1, 1'b1);
    n_cmp++; if ({out_valid, in_ready} !== 2'b10) begin n_bad++; $display("FAIL flush_pre: got v=%b in_ready=%b want 1 0", out_valid, in_ready); end
    tick();
    set_in(1'b0, 20'h0, 1'b1, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    tick();
    set_in(1'b1, (20'd1 << 15) | (20'd5 << 10) | (20'd3 << 5) | 20'd6, 1'b1, 1'b0);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_no_stall: got %b want 1", in_ready); end
    n_cmp++; if (stall_cnt !== 16'(m_stall)) begin n_bad++; $display("FAIL flush_stall_cnt: got %0d want %0d", stall_cnt, m_stall); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== m_valid) begin n_bad++; $display("FAIL midrst_pre_valid: got %b want %b", out_valid, m_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({out_valid, dut_f, stall_cnt} !== '0) begin n_bad++; $display("FAIL midrst_outputs: got v=%b f=%h stall=%0d want zeros", out_valid, dut_f, stall_cnt); end
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [4:0] ops [10];
    logic [4:0] o, a, b, c;
    ops = '{5'd0, 5'd3, 5'd6, 5'd11, 5'd12, 5'd12, 5'd13, 5'd13, 5'd20, 5'd31};
    for (int n = 0; n < 600; n++) begin
      o = ops[$urandom_range(0, 9)];
      a = 5'($urandom_range(0, 3));
      b = 5'($urandom_range(0, 3));
      c = 5'($urandom_range(0, 3)) | (($urandom_range(0, 3) == 0) ? 5'd16 : 5'd0);
      set_in($urandom_range(0, 9) < 7, {o, a, b, c}, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
      n_cmp++; if (in_ready !== m_rdy) begin n_bad++; $display("FAIL rand_in_ready@%0d: got %b want %b", n, in_ready, m_rdy); end
      n_cmp++; if (out_valid !== m_valid) begin n_bad++; $display("FAIL rand_out_valid@%0d: got %b want %b", n, out_valid, m_valid); end
      n_cmp++; if (dut_f !== m) begin n_bad++; $display("FAIL rand_fields@%0d: got %h want %h", n, dut_f, m); end
      n_cmp++; if (stall_cnt !== 16'(m_stall)) begin n_bad++; $display("FAIL rand_stall_cnt@%0d: got %0d want %0d", n, stall_cnt, m_stall); end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_load_use();
    test_held_ld_store();
    test_jtype();
    test_hold();
    test_flush_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
